// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame layout,
// parser states and default widths.
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;

    // Address and length fields are {HI[HI_MSB:0], LO}; HI[RSVD_MSB:RSVD_LSB] must be zero.
    localparam int FIELD_W  = 13;
    localparam int HI_MSB   = 4;
    localparam int RSVD_MSB = 7;
    localparam int RSVD_LSB = 5;

    typedef enum logic [2:0] {
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    function automatic logic rsvd_set(input logic [7:0] b);
        return |b[RSVD_MSB:RSVD_LSB];
    endfunction

endpackage

// File: rtl/ld_csum.sv
// Modulo-256 running sum of payload bytes for frame checksum verification.
module ld_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses an address/length/payload/checksum frame from a byte
// stream, writes the payload into instruction memory and releases the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 csum_clear;
    logic                 csum_add;
    logic [7:0]           sum;
    logic [7:0]           csum_total;
    logic [HI_MSB:0]      hi_q;
    logic [FIELD_W-1:0]   field;
    logic [FIELD_W-1:0]   count_q;
    logic [ADDR_W-1:0]    addr_q;

    assign accept     = in_valid && in_ready;
    assign field      = {hi_q, in_data};
    assign csum_total = sum + in_data;

    ld_csum u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (csum_clear),
        .add_en (csum_add),
        .data   (in_data),
        .sum    (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ADDR_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        csum_clear = 1'b0;
        csum_add   = 1'b0;
        case (state)
            S_ADDR_HI: begin
                in_ready   = 1'b1;
                csum_clear = accept;
                if (accept) state_nxt = rsvd_set(in_data) ? S_ERR : S_ADDR_LO;
            end
            S_ADDR_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (accept) state_nxt = rsvd_set(in_data) ? S_ERR : S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = (field == '0) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
                in_ready = 1'b1;
                csum_add = accept;
                if (accept && count_q == FIELD_W'(1)) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (accept) state_nxt = (csum_total == 8'h00) ? S_DONE : S_ERR;
            end
            default: ;
        endcase
    end

    // The write port is registered: a payload byte accepted on one edge is
    // presented to memory for exactly the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            hi_q      <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_ADDR_HI, S_LEN_HI: hi_q    <= in_data[HI_MSB:0];
                    S_ADDR_LO:           addr_q  <= ADDR_W'(field);
                    S_LEN_LO:            count_q <= field;
                    S_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= DATA_W'(in_data);
                        addr_q    <= addr_q + ADDR_W'(1);
                        count_q   <= count_q - FIELD_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done    = (state == S_DONE);
    assign err     = (state == S_ERR);
    assign cpu_rst = !done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: clean, wrap, bad checksum,
// reserved bits, zero length, back-pressure and mid-frame reset.
module tb_imem_loader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    localparam logic [7:0] CLEAN [8] = '{8'h00, 8'h10, 8'h00, 8'h03, 8'hA9, 8'h15, 8'h0F, 8'h33};
    localparam logic [7:0] BAD   [8] = '{8'h00, 8'h10, 8'h00, 8'h03, 8'hA9, 8'h15, 8'h0F, 8'h34};
    localparam logic [7:0] WRAP  [8] = '{8'h1F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'hCD, 8'h00};
    localparam logic [7:0] ZERO  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [20:0] CLEAN_WR [3] = '{{13'h0010, 8'hA9}, {13'h0011, 8'h15}, {13'h0012, 8'h0F}};

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [20:0] writes[$];

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we !== 1'b0) writes.push_back({mem_addr, mem_wdata});
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        writes.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = 8'hEE;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = b;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr [8], input int n, input bit gap);
        for (int i = 0; i < n; i++) send(fr[i], gap);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({in_ready, cpu_rst, done, err, mem_we} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 11000", {in_ready, cpu_rst, done, err, mem_we});
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== 21'h0) begin
            tests_failed++;
            $display("FAIL reset_mem got %h want 000000", {mem_addr, mem_wdata});
        end
    endtask

    task automatic test_clean_load();
        do_reset();
        for (int i = 0; i < 5; i++) send(CLEAN[i], 1'b0);
        send(CLEAN[5], 1'b0);
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 13'h0010, 8'hA9}) begin
            tests_failed++;
            $display("FAIL clean_latency got %h want %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 13'h0010, 8'hA9});
        end
        send(CLEAN[6], 1'b0);
        send(CLEAN[7], 1'b0);
        idle();
        tests_run++;
        if ({done, err, cpu_rst, in_ready} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL clean_status got %b want 1000", {done, err, cpu_rst, in_ready});
        end
        send(8'h77, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (writes.size() != 3) begin
            tests_failed++;
            $display("FAIL clean_wcount got %0d want 3", writes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (writes[i] !== CLEAN_WR[i]) begin
                    tests_failed++;
                    $display("FAIL clean_write%0d got %h want %h", i, writes[i], CLEAN_WR[i]);
                end
            end
        end
        tests_run++;
        if ({done, err} !== 2'b10) begin
            tests_failed++;
            $display("FAIL clean_hold got %b want 10", {done, err});
        end
    endtask

    task automatic test_wrap();
        logic [20:0] exp_wr [2];
        exp_wr = '{{13'h1FFF, 8'h11}, {13'h0000, 8'h22}};
        do_reset();
        send_frame(WRAP, 7, 1'b0);
        tests_run++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            tests_failed++;
            $display("FAIL wrap_status got %b want 100", {done, err, cpu_rst});
        end
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (writes.size() != 2) begin
            tests_failed++;
            $display("FAIL wrap_wcount got %0d want 2", writes.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (writes[i] !== exp_wr[i]) begin
                    tests_failed++;
                    $display("FAIL wrap_write%0d got %h want %h", i, writes[i], exp_wr[i]);
                end
            end
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        send_frame(BAD, 8, 1'b0);
        tests_run++;
        if ({done, err, cpu_rst, in_ready} !== 4'b0110) begin
            tests_failed++;
            $display("FAIL bad_status got %b want 0110", {done, err, cpu_rst, in_ready});
        end
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (writes.size() != 3) begin
            tests_failed++;
            $display("FAIL bad_wcount got %0d want 3", writes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (writes[i] !== CLEAN_WR[i]) begin
                    tests_failed++;
                    $display("FAIL bad_write%0d got %h want %h", i, writes[i], CLEAN_WR[i]);
                end
            end
        end
    endtask

    task automatic test_reserved_and_zero();
        do_reset();
        send(8'h20, 1'b0);
        idle();
        tests_run++;
        if ({done, err, cpu_rst, in_ready} !== 4'b0110) begin
            tests_failed++;
            $display("FAIL rsvd_addr_status got %b want 0110", {done, err, cpu_rst, in_ready});
        end
        do_reset();
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h40, 1'b0);
        idle();
        tests_run++;
        if ({done, err, in_ready} !== 3'b010) begin
            tests_failed++;
            $display("FAIL rsvd_len_status got %b want 010", {done, err, in_ready});
        end
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (writes.size() != 0) begin
            tests_failed++;
            $display("FAIL rsvd_wcount got %0d want 0", writes.size());
        end
        do_reset();
        send_frame(ZERO, 5, 1'b0);
        tests_run++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            tests_failed++;
            $display("FAIL zero_status got %b want 100", {done, err, cpu_rst});
        end
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (writes.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_wcount got %0d want 0", writes.size());
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send_frame(CLEAN, 8, 1'b1);
        tests_run++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            tests_failed++;
            $display("FAIL gaps_status got %b want 100", {done, err, cpu_rst});
        end
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (writes.size() != 3) begin
            tests_failed++;
            $display("FAIL gaps_wcount got %0d want 3", writes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (writes[i] !== CLEAN_WR[i]) begin
                    tests_failed++;
                    $display("FAIL gaps_write%0d got %h want %h", i, writes[i], CLEAN_WR[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 6; i++) send(CLEAN[i], 1'b0);
        // Reset lands on the same edge that would accept the third payload byte.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = CLEAN[6];
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, cpu_rst, done, err, mem_we} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL midrst_flags got %b want 11000", {in_ready, cpu_rst, done, err, mem_we});
        end
        tests_run++;
        if (writes.size() != 2) begin
            tests_failed++;
            $display("FAIL midrst_wcount got %0d want 2", writes.size());
        end
        writes.delete();
        send_frame(CLEAN, 8, 1'b0);
        tests_run++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            tests_failed++;
            $display("FAIL midrst_reload_status got %b want 100", {done, err, cpu_rst});
        end
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (writes.size() != 3) begin
            tests_failed++;
            $display("FAIL midrst_reload_wcount got %0d want 3", writes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (writes[i] !== CLEAN_WR[i]) begin
                    tests_failed++;
                    $display("FAIL midrst_write%0d got %h want %h", i, writes[i], CLEAN_WR[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_load();
        test_wrap();
        test_bad_csum();
        test_reserved_and_zero();
        test_gaps();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, instruction-memory address width matching the CPU program counter.
REQ-002 SHALL have parameter DATA_W, default 8, instruction byte width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  source presents a frame byte.
REQ-006 SHALL have port in_data  input  8  frame byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per byte.
REQ-009 SHALL have port mem_addr  output  ADDR_W  instruction-memory write address.
REQ-010 SHALL have port mem_wdata  output  DATA_W  instruction-memory write data.
REQ-011 SHALL have port cpu_rst  output  1  holds the CPU in reset until a frame loads cleanly.
REQ-012 SHALL have port done  output  1  frame loaded and checksum good.
REQ-013 SHALL have port err  output  1  frame rejected.

Function
REQ-014 SHALL accept a byte only on a rising edge where in_valid=1 and in_ready=1; in_valid gaps SHALL not advance state.
REQ-015 SHALL parse the frame: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes, then one CSUM byte; address and length are each {HI[4:0], LO} (13 bits).
REQ-016 SHALL use states S_ADDR_HI -> S_ADDR_LO -> S_LEN_HI -> S_LEN_LO -> S_DATA -> S_CSUM -> S_DONE | S_ERR; each arrow taken on one accepted byte.
REQ-017 SHALL go from S_LEN_LO directly to S_CSUM when length = 0.
REQ-018 SHALL go to S_ERR on the accepting edge when ADDR_HI[7:5] or LEN_HI[7:5] is non-zero.
REQ-019 SHALL assert in_ready=1 in S_ADDR_HI..S_CSUM and 0 in S_DONE and S_ERR.
REQ-020 SHALL, for each accepted payload byte, drive mem_we=1, mem_wdata=byte and mem_addr=current address for exactly the following cycle (1-cycle registered latency).
REQ-021 SHALL increment the write address modulo 2^ADDR_W after each payload byte (0x1FFF wraps to 0x0000) and decrement the remaining count; S_DATA ends when the count reaches 0.
REQ-022 SHALL accumulate an 8-bit modulo-256 sum of payload bytes; the frame is good when (sum + CSUM) mod 256 = 0.
REQ-023 SHALL, on accepting CSUM, enter S_DONE if good (done=1, cpu_rst=0 from the next cycle) and S_ERR otherwise (err=1, cpu_rst stays 1).
REQ-024 SHALL hold S_DONE and S_ERR until rst; payload bytes already written are not undone on error.
REQ-025 SHALL keep done and err mutually exclusive and mem_we=0 outside the cycle after a payload acceptance.

Reset
REQ-026 SHALL, when rst=1 on a rising edge, set state=S_ADDR_HI, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, checksum=0 and count=0, including mid-frame.
REQ-027 SHALL give rst priority over a simultaneous byte acceptance (the byte is dropped).

Structure
REQ-028 SHALL take the state enum, ADDR_W/DATA_W defaults and the frame field positions from shared package imem_loader_pkg.
REQ-029 SHALL implement the checksum accumulator as sub-module ld_csum (clear, add-enable, byte in, 8-bit sum out).

Verification
REQ-030 SHALL cover a clean load: 00 10 00 03 A9 15 0F 33 -> writes 0x0010=A9, 0x0011=15, 0x0012=0F; done=1, cpu_rst=0.
REQ-031 SHALL cover wrap-around: 1F FF 00 02 11 22 CD -> writes 0x1FFF=11, 0x0000=22; done=1.
REQ-032 SHALL cover a bad checksum: the REQ-030 frame with CSUM=34 -> three writes, then err=1, done=0, cpu_rst=1, in_ready=0.
REQ-033 SHALL cover a reserved-bit violation and zero length: first byte 20 -> err=1 next cycle, no mem_we; separately 00 00 00 00 00 -> done=1, no mem_we.
REQ-034 SHALL cover back-pressure gaps and reset mid-frame: in_valid toggled each cycle during REQ-030 -> identical writes, no duplicates; rst after 2 payload bytes -> S_ADDR_HI, cpu_rst=1, then a fresh REQ-030 frame succeeds.
